pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/makina_pc_pkg.sv | 19 +
 rtl/pc_ras.sv | 71 +++++++
 rtl/pc_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/makina_pc_pkg.sv
// Shared definitions for the program-counter sequencer.
//   PC_ADDR_W    : default program-counter / address width in bits
//   PC_RESET_VEC : default value pc_out takes while reset is asserted
//   pc_sel_e     : next-PC source select
package makina_pc_pkg;

  localparam int          PC_ADDR_W    = 16;
  localparam int unsigned PC_RESET_VEC = 0;

  typedef enum logic [2:0] {
    HOLD,
    SEQ,
    BRANCH,
    CALL,
    RET,
    TAILCALL
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
//   clk, reset_n : clock, asynchronous active-low reset (pointer/occupancy only)
//   push         : write push_addr as the new top; when full the oldest entry
//                  is overwritten and occupancy stays at RAS_DEPTH
//   pop          : drop the top entry (ignored when empty)
//   replace      : overwrite the top entry with push_addr; acts as push when
//                  empty; takes precedence over push/pop
//   push_addr    : address to write
//   top          : current top entry
//   empty, full  : decoded from registered occupancy
module pc_ras
  import makina_pc_pkg::*;
#(
  parameter int ADDR_W    = PC_ADDR_W,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              replace,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pc_ras: RAS_DEPTH must be a power of two, at least 2");
  end

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     top_ptr;
  logic [CW-1:0]     count;

  // wr_ptr is the next free slot; when full it also points at the oldest
  // entry, so a push there is exactly the circular overwrite.
  assign top_ptr = wr_ptr - PW'(1);
  assign top     = mem[top_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CW'(RAS_DEPTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (replace) begin
      if (empty) begin
        wr_ptr <= wr_ptr + PW'(1);
        count  <= count + CW'(1);
      end
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      count  <= count - CW'(1);
    end
  end

  // Entry storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (replace && !empty) mem[top_ptr] <= push_addr;
    else if (push || replace) mem[wr_ptr] <= push_addr;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with return-address stack.
//   clk           : clock, rising edge
//   reset_n       : asynchronous active-low reset
//   stall         : hold all state (err_clr still acts)
//   branch_taken  : jump to target (ignored with call/ret)
//   branch_rel    : target = pc_out + target_addr instead of target_addr
//   call, ret     : push-and-jump / pop; both together = tail call
//   target_addr   : absolute target or two's-complement offset
//   err_clr       : clear sticky flags (a new error on the same edge wins)
//   pc_out        : registered current PC
//   ras_empty/full: stack occupancy status
//   ras_overflow  : sticky, push while full
//   ras_underflow : sticky, pop while empty
module pc_sequencer
  import makina_pc_pkg::*;
#(
  parameter int          ADDR_W    = PC_ADDR_W,
  parameter int unsigned RESET_VEC = PC_RESET_VEC,
  parameter int unsigned STEP      = 1,
  parameter int          RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic              branch_rel,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] target_addr,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  logic [ADDR_W-1:0]        pc_p0;
  logic [ADDR_W-1:0]        pc_seq;
  logic [ADDR_W-1:0]        pc_next;
  logic [ADDR_W-1:0]        target;
  logic [ADDR_W-1:0]        ras_top;
  logic signed [ADDR_W-1:0] rel_sum;
  pc_sel_e                  sel;
  logic                     push;
  logic                     pop;
  logic                     replace;
  logic                     ovf_set;
  logic                     unf_set;

  assign pc_seq  = pc_p0 + ADDR_W'(STEP);
  assign rel_sum = $signed(pc_p0) + $signed(target_addr);
  assign target  = branch_rel ? $unsigned(rel_sum) : target_addr;
  assign pc_out  = pc_p0;

  always_comb begin
    sel     = SEQ;
    push    = 1'b0;
    pop     = 1'b0;
    replace = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (stall) begin
      sel = HOLD;
    end else if (call && ret) begin
      // Tail call: top entry swapped in place; an empty stack makes it a
      // plain push but is still reported as an underflow.
      sel     = TAILCALL;
      replace = 1'b1;
      unf_set = ras_empty;
    end else if (ret) begin
      pop = 1'b1;
      if (ras_empty) begin
        sel     = SEQ;
        unf_set = 1'b1;
      end else begin
        sel = RET;
      end
    end else if (call) begin
      sel     = CALL;
      push    = 1'b1;
      ovf_set = ras_full;
    end else if (branch_taken) begin
      sel = BRANCH;
    end
  end

  always_comb begin
    pc_next = pc_seq;
    case (sel)
      HOLD:                   pc_next = pc_p0;
      RET:                    pc_next = ras_top;
      CALL, TAILCALL, BRANCH: pc_next = target;
      default:                pc_next = pc_seq;
    endcase
  end

  // Stage p0: architectural PC and sticky error flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_p0         <= ADDR_W'(RESET_VEC);
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc_p0         <= pc_next;
      ras_overflow  <= ovf_set | (ras_overflow & ~err_clr);
      ras_underflow <= unf_set | (ras_underflow & ~err_clr);
    end
  end

  pc_ras #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .replace  (replace),
    .push_addr(pc_seq),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, branch_taken, branch_rel, call, ret, err_clr;
  logic [15:0] target_addr;
  logic [15:0] pc_out;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: return addresses as a queue, newest at the back.
  logic [15:0] m_pc;
  logic [15:0] m_q[$];
  bit          m_ovf, m_unf;

  pc_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_rel   (branch_rel),
    .call         (call),
    .ret          (ret),
    .target_addr  (target_addr),
    .err_clr      (err_clr),
    .pc_out       (pc_out),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] exp_vec();
    return {m_pc, m_q.size() == 0, m_q.size() == DEPTH, m_ovf, m_unf};
  endfunction

  function automatic logic [19:0] got_vec();
    return {pc_out, ras_empty, ras_full, ras_overflow, ras_underflow};
  endfunction

  function automatic int occ();
    return m_q.size();
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000;
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one cycle of requests, advance the model, wait past the edge.
  task automatic apply(input bit st, input bit br, input bit rel, input bit c,
                       input bit r, input logic [15:0] t, input bit clr);
    logic [15:0] tgt, npc;
    bit          novf, nunf;
    stall = st; branch_taken = br; branch_rel = rel; call = c; ret = r;
    target_addr = t; err_clr = clr;
    tgt  = rel ? 16'(m_pc + t) : t;
    npc  = 16'(m_pc + 1);
    novf = 1'b0;
    nunf = 1'b0;
    if (st) begin
      npc = m_pc;
    end else if (c && r) begin
      if (m_q.size() == 0) begin
        m_q.push_back(16'(m_pc + 1));
        nunf = 1'b1;
      end else begin
        m_q[m_q.size()-1] = 16'(m_pc + 1);
      end
      npc = tgt;
    end else if (r) begin
      if (m_q.size() == 0) nunf = 1'b1;
      else npc = m_q.pop_back();
    end else if (c) begin
      if (m_q.size() == DEPTH) begin
        void'(m_q.pop_front());
        novf = 1'b1;
      end
      m_q.push_back(16'(m_pc + 1));
      npc = tgt;
    end else if (br) begin
      npc = tgt;
    end
    m_ovf = novf | (m_ovf & ~clr);
    m_unf = nunf | (m_unf & ~clr);
    @(posedge clk);
    #1;
    m_pc = npc;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 16'h0, 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    stall = 0; branch_taken = 1; branch_rel = 0; call = 1; ret = 0;
    target_addr = 16'h1234; err_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    vectors++;
    if (got_vec() !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", got_vec(), {16'h0000, 4'b1000});
    end
    call = 0; branch_taken = 0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    vectors++;
    if (pc_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_release: pc got %h want 0000", pc_out);
    end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      idle();
      vectors++;
      if (pc_out !== 16'(i) || ras_empty !== 1'b1 || got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL seq_step%0d: got %h want pc=%h empty=1", i, got_vec(), 16'(i));
      end
    end
  endtask

  task automatic test_call_ret();
    apply(0, 1, 0, 0, 0, 16'h0010, 0);
    apply(0, 0, 0, 1, 0, 16'h0100, 0);
    vectors++;
    if (pc_out !== 16'h0100 || ras_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL call_jump: got pc=%h empty=%b want 0100 0", pc_out, ras_empty);
    end
    idle(); idle();
    apply(0, 0, 0, 0, 1, 16'h0, 0);
    vectors++;
    if (got_vec() !== {16'h0011, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL call_return: got %h want %h", got_vec(), {16'h0011, 4'b1000});
    end
  endtask

  task automatic test_rel_branch_wrap();
    apply(0, 1, 0, 0, 0, 16'h0020, 0);
    apply(0, 1, 1, 0, 0, 16'hFFF0, 0);
    vectors++;
    if (pc_out !== 16'h0010) begin
      miscompares++;
      $display("FAIL rel_branch: got %h want 0010", pc_out);
    end
    apply(0, 1, 0, 0, 0, 16'hFFFF, 0);
    idle();
    vectors++;
    if (pc_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL pc_wrap: got %h want 0000", pc_out);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) apply(0, 0, 0, 1, 0, 16'(16'h1000 + i * 16'h10), 0);
    vectors++;
    if (ras_full !== 1'b1 || ras_overflow !== 1'b1 || got_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL overflow: got full=%b ovf=%b want 1 1", ras_full, ras_overflow);
    end
    for (int k = 1; k <= 8; k++) begin
      apply(0, 0, 0, 0, 1, 16'h0, 0);
      vectors++;
      if (pc_out !== 16'(16'h1001 + (8 - k) * 16'h10) || got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL ret_order%0d: got %h want %h", k, pc_out, 16'(16'h1001 + (8 - k) * 16'h10));
      end
    end
    vectors++;
    if (ras_empty !== 1'b1 || ras_underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL drained: got empty=%b unf=%b want 1 0", ras_empty, ras_underflow);
    end
    apply(0, 0, 0, 0, 1, 16'h0, 0);
    vectors++;
    if (pc_out !== 16'h1002 || ras_underflow !== 1'b1 || ras_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL underflow: got pc=%h unf=%b want 1002 1", pc_out, ras_underflow);
    end
  endtask

  task automatic test_err_clr();
    apply(0, 0, 0, 0, 0, 16'h0, 1);
    vectors++;
    if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clr: got ovf=%b unf=%b want 0 0", ras_overflow, ras_underflow);
    end
    apply(0, 0, 0, 0, 1, 16'h0, 1);
    vectors++;
    if (ras_underflow !== 1'b1 || ras_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL err_set_wins: got unf=%b ovf=%b want 1 0", ras_underflow, ras_overflow);
    end
    apply(1, 0, 0, 0, 0, 16'h0, 1);
    vectors++;
    if (ras_underflow !== 1'b0 || got_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL clr_in_stall: got unf=%b want 0", ras_underflow);
    end
  endtask

  task automatic test_stall();
    logic [15:0] pc0;
    apply(0, 0, 0, 1, 0, 16'h0300, 0);
    pc0 = pc_out;
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 0, 1, 0, 16'h0500, 0);
      vectors++;
      if (pc_out !== pc0 || ras_empty !== 1'b0 || occ() != 1 || got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL stall%0d: got %h want %h", i, got_vec(), exp_vec());
      end
    end
    apply(0, 0, 0, 0, 1, 16'h0, 0);
    vectors++;
    if (got_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL stall_ret: got %h want %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_tail_call();
    apply(0, 0, 0, 1, 1, 16'h0700, 0);
    vectors++;
    if (pc_out !== 16'h0700 || ras_underflow !== 1'b1 || got_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL tail_empty: got %h want %h", got_vec(), exp_vec());
    end
    apply(0, 0, 0, 1, 1, 16'h0800, 1);
    vectors++;
    if (got_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL tail_replace: got %h want %h", got_vec(), exp_vec());
    end
    apply(0, 1, 0, 0, 1, 16'h0900, 0);
    vectors++;
    if (pc_out !== 16'h0701 || got_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL tail_ret: got %h want pc=0701 %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 1, 0, 16'(16'h2000 + i), 0);
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (pc_out !== 16'h0000 || ras_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: got pc=%h empty=%b want 0000 1", pc_out, ras_empty);
    end
    #1;
    reset_n = 1'b1;
    model_reset();
    idle();
    vectors++;
    if (got_vec() !== {16'h0001, 4'b1000}) begin
      miscompares++;
      $display("FAIL post_reset: got %h want %h", got_vec(), {16'h0001, 4'b1000});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      bit          st, br, rel, c, r, clr;
      logic [15:0] t;
      st  = ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 3) == 0);
      rel = $urandom_range(0, 1);
      c   = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 15) == 0);
      t   = 16'($urandom);
      apply(st, br, rel, c, r, t, clr);
      vectors++;
      if (got_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random%0d: got %h want %h", n, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_call_ret();
    test_rel_branch_wrap();
    test_overflow();
    test_err_clr();
    test_stall();
    test_tail_call();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
